// File: rtl/systolic_pkg.sv
// Shared constants and FSM state encoding for the systolic feeder.
package systolic_pkg;
  localparam int ARRAY_DIM     = 4;
  localparam int DATA_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;
endpackage

// File: rtl/systolic_feeder_if.sv
// Weight-row and activation-vector valid/ready streams into the feeder.
interface systolic_feeder_if
  import systolic_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
);
  logic                           w_valid;
  logic                           w_ready;
  logic [DATA_BITS*ARRAY_DIM-1:0] w_data;
  logic                           a_valid;
  logic                           a_ready;
  logic [DATA_BITS*ARRAY_DIM-1:0] a_data;
  logic                           a_last;

  modport master (
    output w_valid, w_data,
    output a_valid, a_data, a_last,
    input  w_ready, a_ready
  );

  modport slave (
    input  w_valid, w_data,
    input  a_valid, a_data, a_last,
    output w_ready, a_ready
  );
endinterface

// File: rtl/skew_line.sv
// Fixed-depth delay line for one activation lane (data plus valid).
module skew_line #(
  parameter int W = 8,
  parameter int D = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         vin,
  output logic [W-1:0] dout,
  output logic         vout
);
  logic [W-1:0] data_q [D];
  logic         vld_q  [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      data_q[0] <= din;
      vld_q[0]  <= vin;
      for (int i = 1; i < D; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign dout = data_q[D-1];
  assign vout = vld_q[D-1];
endmodule

// File: rtl/systolic_feeder.sv
// Loads a 4-row weight tile, then streams skewed activations into the array.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  systolic_feeder_if.slave               bus,
  output logic [0:ARRAY_DIM-1]           propagate,
  output logic [DATA_BITS*ARRAY_DIM-1:0] weight,
  output logic [DATA_BITS*ARRAY_DIM-1:0] activation,
  output logic [0:ARRAY_DIM-1]           act_valid,
  output logic                           busy,
  output logic                           done
);
  // Last drain count: lane 3's final slot is presented before DONE.
  localparam logic [2:0] DRAIN_LAST = 3'd3;

  state_t     state_q, state_d;
  logic [1:0] row_q;
  logic [2:0] drain_q;
  logic       w_fire;
  logic       a_fire;

  assign w_fire = bus.w_valid & bus.w_ready;
  assign a_fire = bus.a_valid & bus.a_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      if (w_fire) row_q <= row_q + 2'd1;
      drain_q <= (state_q == DRAIN) ? drain_q + 3'd1 : 3'd0;
    end
  end

  always_comb begin
    state_d     = state_q;
    bus.w_ready = 1'b0;
    bus.a_ready = 1'b0;
    busy        = (state_q != IDLE);
    done        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = LOAD_W;
      end
      LOAD_W: begin
        bus.w_ready = 1'b1;
        if (bus.w_valid && row_q == 2'd3) state_d = STREAM;
      end
      STREAM: begin
        bus.a_ready = 1'b1;
        if (bus.a_valid && bus.a_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q == DRAIN_LAST) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      propagate <= '0;
      weight    <= '0;
    end else begin
      propagate <= w_fire ? '1 : '0;
      if (w_fire) weight <= bus.w_data;
    end
  end

  for (genvar r = 0; r < ARRAY_DIM; r++) begin : g_lane
    skew_line #(
      .W (DATA_BITS),
      .D (r + 1)
    ) u_line (
      .clk  (clk),
      .rst  (rst),
      .din  (a_fire ? bus.a_data[r*DATA_BITS +: DATA_BITS] : '0),
      .vin  (a_fire),
      .dout (activation[r*DATA_BITS +: DATA_BITS]),
      .vout (act_valid[r])
    );
  end
endmodule
